ddr3_pll_rst_seq: RTL and testbench
===================================

# ddr3_pll_rst_seq

Reset sequencer for the DDR3 clock PLL, running on the free-running 50 MHz board clock that also feeds the PLL input. It drives the PLL's active-high reset, qualifies the asynchronous lock output, and releases the DDR3 controller reset only after lock has been stable for a programmable time. Lock timeouts are retried a bounded number of times. Loss of lock during operation restarts the whole sequence.

## Interface
Parameters:
- RST_CYCLES, 16: width of the PLL reset pulse, in clk cycles (≥1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before release (≥1).
- LOCK_TIMEOUT_CYCLES, 50000: maximum wait for lock after a PLL reset pulse (1 ms at 50 MHz).
- MAX_RETRY, 3: number of timeouts tolerated before FAULT (1..7).

Ports:
- clk, in, 1: 50 MHz reference clock, the same net as the PLL clkin. Single clock domain.
- rst_n, in, 1: synchronous, active-low reset.
- pll_lock, in, 1: PLL lock output. Asynchronous to clk; synchronized internally with 2 flops.
- relock_req, in, 1: single-cycle request to restart the sequence. Also clears retry_cnt and FAULT.
- pll_reset, out, 1: to the PLL reset input, active high.
- ddr_rst_n, out, 1: DDR3 controller reset, active low.
- ready, out, 1: high in RUN.
- fault, out, 1: high in FAULT.
- retry_cnt, out, 3: number of lock timeouts since the last rst_n or relock_req.

## Operation
- lock_s is pll_lock after the 2-flop synchronizer. All decisions use lock_s.
- All outputs are registered and are decoded from the next state.
- One shared counter, cnt, is wide enough for the largest parameter. It clears on every state transition.

States:
- RESET_PLL
  - pll_reset=1.
  - When cnt==RST_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK
  - pll_reset=0.
  - lock_s=1: go to STABLE.
  - Otherwise, when cnt==LOCK_TIMEOUT_CYCLES-1: retry_cnt+1.
    - If the new value equals MAX_RETRY, go to FAULT.
    - Otherwise go to RESET_PLL.
- STABLE
  - lock_s=0: go to WAIT_LOCK. This is a glitch, not a timeout; retry_cnt is unchanged and the timeout restarts.
  - When cnt==LOCK_STABLE_CYCLES-1 with lock_s=1: go to RUN.
- RUN
  - ddr_rst_n=1, ready=1.
  - lock_s=0: go to RESET_PLL. ddr_rst_n and ready fall on that same edge.
- FAULT
  - pll_reset=1, fault=1, ddr_rst_n=0.
  - Held until rst_n or relock_req.

Global rules:
- relock_req=1 in any state goes to RESET_PLL and sets retry_cnt=0. It has priority over every other transition.
- rst_n=0 has priority over relock_req.
- rst_n low mid-sequence applies reset values on the next edge, regardless of state.

Reset values:
- state=RESET_PLL, cnt=0, synchronizer flops=0.
- pll_reset=1, ddr_rst_n=0, ready=0, fault=0, retry_cnt=0.

## Timing
- Synchronizer latency: 2 cycles, plus up to 1 cycle of asynchronous alignment.
- pll_reset pulse: pll_reset stays high for exactly RST_CYCLES edges after the first edge that samples rst_n=1.
- Lock to release: the edge that first sees lock_s=1 in WAIT_LOCK enters STABLE. ddr_rst_n/ready rise exactly LOCK_STABLE_CYCLES edges later, with no drop of lock_s in between.
- Timeout: WAIT_LOCK lasts exactly LOCK_TIMEOUT_CYCLES cycles when lock_s stays 0. retry_cnt increments on the exit edge.
- Loss of lock in RUN: ddr_rst_n falls 1 edge after lock_s falls, which is 3 edges after pll_lock falls. pll_reset rises on the same edge.
- relock_req: takes effect on the next edge. pll_reset=1 and ddr_rst_n=0 on that edge.
- Simultaneous events, priority order: rst_n > relock_req > lock_s loss > timeout/stable-count completion.

## Configuration
- DDR3_PLL_RETRY_EN defined:
  - Timeout retry as described above.
  - FAULT is reached after MAX_RETRY timeouts.
- DDR3_PLL_RETRY_EN undefined:
  - The first WAIT_LOCK timeout goes directly to FAULT.
  - retry_cnt is held at 0, and the retry counter logic is removed.
  - All other behaviour is identical.

## Test plan
- Nominal lock:
  - Stimulus: release rst_n; raise pll_lock 100 cycles after pll_reset falls; RST_CYCLES=16, LOCK_STABLE_CYCLES=1024.
  - Required: pll_reset high for exactly 16 cycles; ddr_rst_n and ready rise 1026–1027 cycles after pll_lock rises; fault=0; retry_cnt=0.
- Lock glitch during STABLE:
  - Stimulus: drop pll_lock for 1 cycle at stable count 500.
  - Required: return to WAIT_LOCK, then STABLE; ddr_rst_n is delayed by a full further 1024 cycles; retry_cnt stays 0.
- Timeout and retry:
  - Stimulus: pll_lock held at 0; LOCK_TIMEOUT_CYCLES=64, MAX_RETRY=3.
  - Required: three reset pulses of 16 cycles, each followed by a 64-cycle wait; retry_cnt steps 1, 2, 3; fault=1; pll_reset=1 held.
  - Without DDR3_PLL_RETRY_EN: fault after the first 64-cycle wait, retry_cnt=0.
- Loss of lock in RUN:
  - Stimulus: drop pll_lock while ready=1.
  - Required: ddr_rst_n=0 and pll_reset=1 within 3–4 cycles; a full sequence follows; ready returns once lock is restored.
- Recovery from FAULT and relock:
  - Stimulus: pulse relock_req in FAULT.
  - Required: fault=0, retry_cnt=0, pll_reset=1 on the next edge.
- Simultaneous rst_n and relock_req:
  - Stimulus: assert rst_n low together with relock_req while in RUN.
  - Required: reset values on the next edge.

Source files
------------

// File: rtl/ddr3_pll_rst_seq.sv
// DDR3 PLL reset sequencer: pulses the PLL reset, qualifies lock, then releases the controller reset.
// Optional feature macro: DDR3_PLL_RETRY_EN enables bounded retry of lock timeouts before FAULT.
module ddr3_pll_rst_seq #(
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRY           = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       ddr_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [2:0] retry_cnt
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    logic             lock_p0;
    logic             lock_s;
    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             restart;

`ifdef DDR3_PLL_RETRY_EN
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    logic [2:0] retry_next;

    function automatic logic [2:0] retry_inc(input logic [2:0] r);
        return (r == 3'd7) ? r : r + 3'd1;
    endfunction
`else
    logic unused_retry_cfg;
    assign unused_retry_cfg = (MAX_RETRY > 0);
`endif

    // Next-state decode; relock_req overrides every state-local transition.
    always_comb begin
        state_next = state;
`ifdef DDR3_PLL_RETRY_EN
        retry_next = retry_cnt;
`endif
        case (state)
            S_RESET_PLL: begin
                if (cnt == RST_LAST) state_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
`ifdef DDR3_PLL_RETRY_EN
                    retry_next = retry_inc(retry_cnt);
                    state_next = (retry_next == RETRY_LIMIT) ? S_FAULT : S_RESET_PLL;
`else
                    state_next = S_FAULT;
`endif
                end
            end
            S_STABLE: begin
                // A lock drop here is a glitch: back to waiting with a fresh timeout.
                if (!lock_s) state_next = S_WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_next = S_RUN;
            end
            S_RUN: begin
                if (!lock_s) state_next = S_RESET_PLL;
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_RESET_PLL;
            end
        endcase

        if (relock_req) begin
            state_next = S_RESET_PLL;
`ifdef DDR3_PLL_RETRY_EN
            retry_next = 3'd0;
`endif
        end
    end

    // A relock in RESET_PLL keeps the state but must still restart the pulse.
    assign restart = relock_req || (state_next != state);

    always_comb begin
        cnt_next = '0;
        if (!restart) begin
            if (state == S_RESET_PLL || state == S_WAIT_LOCK || state == S_STABLE)
                cnt_next = cnt + CNT_W'(1);
        end
    end

    // Synchronizer and state registers; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_p0   <= 1'b0;
            lock_s    <= 1'b0;
            state     <= S_RESET_PLL;
            cnt       <= '0;
            pll_reset <= 1'b1;
            ddr_rst_n <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= 3'd0;
        end else begin
            lock_p0   <= pll_lock;
            lock_s    <= lock_p0;
            state     <= state_next;
            cnt       <= cnt_next;
            pll_reset <= (state_next == S_RESET_PLL) || (state_next == S_FAULT);
            ddr_rst_n <= (state_next == S_RUN);
            ready     <= (state_next == S_RUN);
            fault     <= (state_next == S_FAULT);
`ifdef DDR3_PLL_RETRY_EN
            retry_cnt <= retry_next;
`else
            retry_cnt <= 3'd0;
`endif
        end
    end

endmodule

// File: tb/tb_ddr3_pll_rst_seq.sv
// Self-checking bench for ddr3_pll_rst_seq: event-deadline reference model plus directed scenarios.
module tb_ddr3_pll_rst_seq;

    localparam int RST  = 16;
    localparam int STB  = 1024;
    localparam int TMO  = 64;
    localparam int MR   = 3;

    localparam int P_RST = 0;
    localparam int P_WAIT = 1;
    localparam int P_STB = 2;
    localparam int P_RUN = 3;
    localparam int P_FLT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_reset;
    logic       ddr_rst_n;
    logic       ready;
    logic       fault;
    logic [2:0] retry_cnt;

    int checks = 0;
    int failures = 0;

    ddr3_pll_rst_seq #(
        .RST_CYCLES(RST),
        .LOCK_STABLE_CYCLES(STB),
        .LOCK_TIMEOUT_CYCLES(TMO),
        .MAX_RETRY(MR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pll_lock(pll_lock),
        .relock_req(relock_req),
        .pll_reset(pll_reset),
        .ddr_rst_n(ddr_rst_n),
        .ready(ready),
        .fault(fault),
        .retry_cnt(retry_cnt)
    );

    always #10 clk = ~clk;

    // Reference model: each phase has an absolute exit deadline measured in edges.
    int now = 0;
    int ph = P_RST;
    int dl = 0;
    int m_retry = 0;
    bit model_on = 1'b0;
    bit lk;
    bit lock_hist [2];

    always @(posedge clk) begin
        now = now + 1;
        if (!rst_n) begin
            ph = P_RST;
            dl = now + RST;
            m_retry = 0;
            lock_hist[0] = 1'b0;
            lock_hist[1] = 1'b0;
            model_on = 1'b1;
        end else begin
            lk = lock_hist[1];
            lock_hist[1] = lock_hist[0];
            lock_hist[0] = pll_lock;
            if (relock_req) begin
                ph = P_RST;
                dl = now + RST;
                m_retry = 0;
            end else if (ph == P_RST) begin
                if (now == dl) begin ph = P_WAIT; dl = now + TMO; end
            end else if (ph == P_WAIT) begin
                if (lk) begin
                    ph = P_STB; dl = now + STB;
                end else if (now == dl) begin
`ifdef DDR3_PLL_RETRY_EN
                    m_retry = m_retry + 1;
                    if (m_retry == MR) ph = P_FLT;
                    else begin ph = P_RST; dl = now + RST; end
`else
                    ph = P_FLT;
`endif
                end
            end else if (ph == P_STB) begin
                if (!lk) begin ph = P_WAIT; dl = now + TMO; end
                else if (now == dl) ph = P_RUN;
            end else if (ph == P_RUN) begin
                if (!lk) begin ph = P_RST; dl = now + RST; end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            logic [6:0] act, exp;
            act = {pll_reset, ddr_rst_n, ready, fault, retry_cnt};
            exp = {(ph == P_RST || ph == P_FLT), (ph == P_RUN), (ph == P_RUN),
                   (ph == P_FLT), 3'(m_retry)};
            checks = checks + 1;
            if (act !== exp) begin
                failures = failures + 1;
                $display("FAIL cycle_compare t=%0t actual={prst,ddr,rdy,flt,retry}=%b required=%b",
                         $time, act, exp);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Edges until the selected output equals val (checked at the following negedge); -1 if never.
    task automatic count_edges(input int which, input logic val, input int limit, output int n);
        logic s;
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            @(negedge clk);
            case (which)
                0: s = pll_reset;
                1: s = ready;
                2: s = ddr_rst_n;
                default: s = fault;
            endcase
            if (s === val) begin
                n = i;
                return;
            end
        end
    endtask

    int n;
    int fault_edges;
    int final_retry;

    initial begin
`ifdef DDR3_PLL_RETRY_EN
        fault_edges = 3 + MR * (RST + TMO);
        final_retry = MR;
`else
        fault_edges = 3 + RST + TMO;
        final_retry = 0;
`endif
        repeat (3) @(negedge clk);
        check("reset_pll_reset", int'(pll_reset), 1);
        check("reset_ddr_rst_n", int'(ddr_rst_n), 0);
        check("reset_ready", int'(ready), 0);
        check("reset_fault", int'(fault), 0);
        check("reset_retry_cnt", int'(retry_cnt), 0);

        // Nominal lock
        rst_n = 1'b1;
        count_edges(0, 1'b0, 100, n);
        check("pll_reset_pulse_edges", n, RST);
        repeat (29) @(negedge clk);
        pll_lock = 1'b1;
        count_edges(1, 1'b1, 2000, n);
        check("lock_to_ready_edges", n, STB + 3);
        check("nominal_ddr_rst_n", int'(ddr_rst_n), 1);
        check("nominal_retry_cnt", int'(retry_cnt), 0);

        // Loss of lock in RUN, then glitch during STABLE
        pll_lock = 1'b0;
        count_edges(2, 1'b0, 10, n);
        check("loss_to_ddr_rst_edges", n, 3);
        check("loss_pll_reset", int'(pll_reset), 1);
        count_edges(0, 1'b0, 40, n);
        check("relock_pulse_edges", n, RST);
        repeat (9) @(negedge clk);
        pll_lock = 1'b1;
        repeat (503) @(negedge clk);
        check("stable_not_ready_yet", int'(ready), 0);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        count_edges(1, 1'b1, 2000, n);
        check("glitch_restore_to_ready_edges", n, STB + 3);
        check("glitch_retry_cnt", int'(retry_cnt), 0);

        // Timeout path with lock held low
        pll_lock = 1'b0;
        count_edges(3, 1'b1, 1000, n);
        check("loss_to_fault_edges", n, fault_edges);
        check("fault_retry_cnt", int'(retry_cnt), final_retry);
        check("fault_pll_reset", int'(pll_reset), 1);
        check("fault_ddr_rst_n", int'(ddr_rst_n), 0);
        repeat (20) @(negedge clk);
        check("fault_held", int'(fault), 1);

        // Recovery from FAULT via relock_req
        relock_req = 1'b1;
        @(negedge clk);
        relock_req = 1'b0;
        check("relock_fault", int'(fault), 0);
        check("relock_retry_cnt", int'(retry_cnt), 0);
        check("relock_pll_reset", int'(pll_reset), 1);
        pll_lock = 1'b1;
        count_edges(1, 1'b1, 2000, n);
        check("relock_to_ready_edges", n, RST + 1 + STB);

        // rst_n and relock_req together in RUN
        rst_n = 1'b0;
        relock_req = 1'b1;
        @(negedge clk);
        check("simul_pll_reset", int'(pll_reset), 1);
        check("simul_ddr_rst_n", int'(ddr_rst_n), 0);
        check("simul_ready", int'(ready), 0);
        check("simul_fault", int'(fault), 0);
        check("simul_retry_cnt", int'(retry_cnt), 0);
        rst_n = 1'b1;
        relock_req = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
